// File: rtl/case1_sweep_ctrl.sv
// case1_sweep_ctrl: exhaustive-sweep self-check sequencer for the case1 gate
// network. On start it walks all 16 {a,b,c,d} vectors into an external case1
// instance, samples {x,y,z} after SETTLE cycles per vector, and compares them
// against the GOLDEN truth table. It reports pass/fail, the mismatch count and
// the first failing vector.
// Optional feature: define CASE1_SWEEP_MISR_EN to build a 16-bit MISR
// (x^16+x^12+x^3+x+1) over {v,x,y,z}. Without it, sig_o is tied to 0.
module case1_sweep_ctrl #(
  parameter int unsigned SETTLE = 1,                   // hold cycles per vector, 1..15
  parameter logic [47:0] GOLDEN = 48'h0072_9529_53B4   // {x,y,z} of vector v at [3v+2:3v]
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  output logic [3:0]  vec_o,
  input  logic        x_i,
  input  logic        y_i,
  input  logic        z_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        pass_o,
  output logic [4:0]  err_cnt_o,
  output logic        fail_vld_o,
  output logic [3:0]  first_fail_o,
  output logic [15:0] sig_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Settle counter value on the last cycle of a vector hold.
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
  // 16 vectors means at most 16 mismatches; the counter never needs to wrap.
  localparam logic [4:0] ERR_MAX     = 5'd16;
  localparam logic [3:0] VEC_LAST    = 4'd15;

  state_t     state;
  logic [3:0] settle_cnt;
  logic [2:0] xyz;
  logic [2:0] xyz_exp;
  logic       hold_last;
  logic       sweep_start;
  logic       sample_en;
  logic       mismatch;
  logic [4:0] err_nxt;

  // Golden {x,y,z} for vector v; a small mux over the 16 table entries.
  function automatic logic [2:0] golden_xyz(input logic [3:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (v == 4'(i)) r = GOLDEN[3*i +: 3];
    end
    return r;
  endfunction

  assign xyz         = {x_i, y_i, z_i};
  assign xyz_exp     = golden_xyz(vec_o);
  assign hold_last   = (settle_cnt == SETTLE_LAST);
  // Abort beats start in IDLE, and beats the sample on the abort edge in RUN.
  assign sweep_start = (state == S_IDLE) && start_i && !abort_i;
  assign sample_en   = (state == S_RUN) && !abort_i && hold_last;
  assign mismatch    = (xyz != xyz_exp);

  // Next error count including the vector being sampled, saturating at 16.
  always_comb begin
    // NOTE: default assignment first so every path drives err_nxt and no latch is inferred.
    err_nxt = err_cnt_o;
    if (mismatch && (err_cnt_o != ERR_MAX)) err_nxt = err_cnt_o + 5'd1;
  end

  // Sweep FSM with registered outputs: IDLE -> RUN (16 vectors) -> DONE -> IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      state        <= S_IDLE;
      settle_cnt   <= '0;
      vec_o        <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      pass_o       <= 1'b0;
      err_cnt_o    <= '0;
      fail_vld_o   <= 1'b0;
      first_fail_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sweep_start) begin
            state        <= S_RUN;
            busy_o       <= 1'b1;
            vec_o        <= '0;
            settle_cnt   <= '0;
            pass_o       <= 1'b0;
            err_cnt_o    <= '0;
            fail_vld_o   <= 1'b0;
            first_fail_o <= '0;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            // Partial results stay visible for debug; pass_o remains 0.
            state      <= S_IDLE;
            busy_o     <= 1'b0;
            vec_o      <= '0;
            settle_cnt <= '0;
          end else if (sample_en) begin
            settle_cnt <= '0;
            err_cnt_o  <= err_nxt;
            if (mismatch && !fail_vld_o) begin
              fail_vld_o   <= 1'b1;
              first_fail_o <= vec_o;
            end
            if (vec_o == VEC_LAST) begin
              state  <= S_DONE;
              busy_o <= 1'b0;
              vec_o  <= '0;
              done_o <= 1'b1;
              pass_o <= (err_nxt == '0);
            end else begin
              vec_o <= vec_o + 4'd1;
            end
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_DONE: begin
          // Single-cycle state so done_o is a one-cycle pulse; restart from IDLE.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CASE1_SWEEP_MISR_EN
  localparam logic [15:0] MISR_POLY = 16'h100B;  // x^12 + x^3 + x + 1 taps

  logic [15:0] misr;

  // One Galois MISR step: shift left, fold the x^16 term back, absorb data.
  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? MISR_POLY : 16'h0000) ^ d;
  endfunction

  // Signature register: cleared on sweep start, advanced at every sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misr <= '0;
    end else if (sweep_start) begin
      misr <= '0;
    end else if (sample_en) begin
      misr <= misr_step(misr, {9'b0, vec_o, xyz});
    end
  end

  assign sig_o = misr;
`else
  assign sig_o = '0;
`endif

endmodule

// File: tb/tb_case1_sweep_ctrl.sv
// tb_case1_sweep_ctrl: two sequencers (SETTLE=1 and SETTLE=4), each driving a
// behavioural case1 stand-in with selectable faults. A sweep-level model,
// expressed as "cycles since start", predicts every output every cycle;
// directed scenarios pin the model with hand-computed values, then random
// start/abort/reset/fault traffic runs against the same model.
`timescale 1ns/1ps
module tb_case1_sweep_ctrl;

  localparam logic [47:0] GOLDEN = 48'h0072_9529_53B4;
  localparam int NI = 2;

  // Fault modes of the case1 stand-in.
  localparam int F_NONE   = 0;
  localparam int F_Z0     = 1;  // z stuck at 0
  localparam int F_XINV   = 2;  // x inverted
  localparam int F_Y5FLIP = 3;  // y flipped at v=5 only

  logic        clk = 1'b0;
  logic        rst_n [NI];
  logic        start [NI];
  logic        abort [NI];
  logic [3:0]  vec   [NI];
  logic        x     [NI];
  logic        y     [NI];
  logic        z     [NI];
  logic        busy  [NI];
  logic        done  [NI];
  logic        pass  [NI];
  logic [4:0]  err   [NI];
  logic        fvld  [NI];
  logic [3:0]  ff    [NI];
  logic [15:0] sig   [NI];
  int          fault [NI];

  int n_vec = 0;
  int n_mis = 0;

  // Model state per instance: phase 0 idle, 1 run, 2 done pulse.
  int       m_phase [NI];
  int       m_k     [NI];  // cycles spent in RUN so far
  int       m_err   [NI];
  bit       m_fvld  [NI];
  int       m_ff    [NI];
  bit       m_pass  [NI];
  bit [15:0] m_sig  [NI];

  always #5 clk = ~clk;

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Behavioural case1: the golden truth table with an optional fault applied.
  function automatic logic [2:0] resp(input int f, input logic [3:0] v);
    logic [47:0] g;
    logic [2:0]  r;
    g = GOLDEN;
    r = g[3*int'(v) +: 3];
    case (f)
      F_Z0:     r[0] = 1'b0;
      F_XINV:   r[2] = ~r[2];
      F_Y5FLIP: if (v == 4'd5) r[1] = ~r[1];
      default:  ;
    endcase
    return r;
  endfunction

  function automatic bit [15:0] misr_step(input bit [15:0] s, input bit [15:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ d;
  endfunction

  assign {x[0], y[0], z[0]} = resp(fault[0], vec[0]);
  assign {x[1], y[1], z[1]} = resp(fault[1], vec[1]);

  case1_sweep_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n[0]), .start_i(start[0]), .abort_i(abort[0]),
    .vec_o(vec[0]), .x_i(x[0]), .y_i(y[0]), .z_i(z[0]),
    .busy_o(busy[0]), .done_o(done[0]), .pass_o(pass[0]), .err_cnt_o(err[0]),
    .fail_vld_o(fvld[0]), .first_fail_o(ff[0]), .sig_o(sig[0])
  );

  case1_sweep_ctrl #(.SETTLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n[1]), .start_i(start[1]), .abort_i(abort[1]),
    .vec_o(vec[1]), .x_i(x[1]), .y_i(y[1]), .z_i(z[1]),
    .busy_o(busy[1]), .done_o(done[1]), .pass_o(pass[1]), .err_cnt_o(err[1]),
    .fail_vld_o(fvld[1]), .first_fail_o(ff[1]), .sig_o(sig[1])
  );

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [32:0] act_of(input int i);
    return {vec[i], busy[i], done[i], pass[i], err[i], fvld[i], ff[i], sig[i]};
  endfunction

  function automatic logic [32:0] exp_of(input int i);
    logic [3:0] ev;
    ev = (m_phase[i] == 1) ? 4'(m_k[i] / settle_of(i)) : 4'd0;
    return {ev, m_phase[i] == 1, m_phase[i] == 2, m_pass[i], 5'(m_err[i]),
            m_fvld[i], 4'(m_ff[i]), m_sig[i]};
  endfunction

  function automatic logic [10:0] res_of(input int i);
    return {pass[i], err[i], fvld[i], ff[i]};
  endfunction

  task automatic model_clear(input int i);
    m_k[i] = 0; m_err[i] = 0; m_fvld[i] = 0; m_ff[i] = 0; m_pass[i] = 0; m_sig[i] = '0;
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step(input int i);
    int s;
    int v;
    logic [2:0]  r;
    logic [47:0] g;
    s = settle_of(i);
    g = GOLDEN;
    if (!rst_n[i]) begin
      m_phase[i] = 0;
      model_clear(i);
    end else begin
      case (m_phase[i])
        0: if (start[i] && !abort[i]) begin
             m_phase[i] = 1;
             model_clear(i);
           end
        1: if (abort[i]) begin
             m_phase[i] = 0;
           end else begin
             v = m_k[i] / s;
             if (m_k[i] % s == s - 1) begin
               r = resp(fault[i], 4'(v));
               if (r != g[3*v +: 3]) begin
                 if (m_err[i] < 16) m_err[i]++;
                 if (!m_fvld[i]) begin
                   m_fvld[i] = 1;
                   m_ff[i]   = v;
                 end
               end
`ifdef CASE1_SWEEP_MISR_EN
               m_sig[i] = misr_step(m_sig[i], {9'b0, 4'(v), r});
`endif
               if (v == 15) begin
                 m_phase[i] = 2;
                 m_pass[i]  = (m_err[i] == 0);
               end
             end
             m_k[i]++;
           end
        default: m_phase[i] = 0;
      endcase
    end
  endtask

  // Every cycle: compare both DUTs against the model, then advance it.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      check($sformatf("cycle_dut%0d", i), act_of(i), exp_of(i));
      model_step(i);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on instance i and return the start-to-done latency in cycles.
  task automatic run(input int i, input bit extra_start, output int lat);
    lat = 0;
    start[i] = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      tick();
      start[i] = (extra_start && c == 5);
      if (done[i]) begin
        lat = c;
        break;
      end
    end
    start[i] = 1'b0;
    check($sformatf("done_seen_dut%0d", i), 33'(done[i]), 33'd1);
  endtask

  task automatic wait_vec(input int i, input logic [3:0] n);
    for (int c = 0; c < 200 && !(busy[i] && vec[i] == n); c++) tick();
    check($sformatf("reach_v%0d", n), {busy[i], vec[i]}, {1'b1, n});
  endtask

  bit [15:0] gold_sig;

  initial begin
    int lat;
    int seen;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0; start[i] = 1'b0; abort[i] = 1'b0; fault[i] = F_NONE;
    end
    repeat (3) tick();
    check("reset_dut1", act_of(0), 33'd0);
    check("reset_dut4", act_of(1), 33'd0);
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;
    tick();

    // Correct model, SETTLE=1.
    run(0, 1'b0, lat);
    check("lat_s1", 33'(lat), 33'd17);
    check("res_good", 33'(res_of(0)), 33'({1'b1, 5'd0, 1'b0, 4'd0}));
    tick();

    // z stuck at 0: mismatches at 3,4,7,8,11,12.
    fault[0] = F_Z0;
    run(0, 1'b0, lat);
    check("res_z0", 33'(res_of(0)), 33'({1'b0, 5'd6, 1'b1, 4'd3}));
    tick();

    // SETTLE=4, x inverted: every vector fails.
    fault[1] = F_XINV;
    run(1, 1'b0, lat);
    check("lat_s4", 33'(lat), 33'd65);
    check("res_xinv", 33'(res_of(1)), 33'({1'b0, 5'd16, 1'b1, 4'd0}));
    fault[1] = F_NONE;
    tick();

    // Abort at v=7 with z stuck: vectors 0..6 sampled, so 2 errors, first 3.
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_vec(0, 4'd7);
    abort[0] = 1'b1; tick(); abort[0] = 1'b0;
    check("abort_idle", 33'({busy[0], vec[0]}), 33'd0);
    check("abort_partial", 33'(res_of(0)), 33'({1'b0, 5'd2, 1'b1, 4'd3}));
    seen = 0;
    repeat (20) begin
      tick();
      if (done[0] || busy[0]) seen++;
    end
    check("abort_no_done", 33'(seen), 33'd0);

    // start together with abort in IDLE: no sweep.
    fault[0] = F_NONE;
    start[0] = 1'b1; abort[0] = 1'b1; tick();
    start[0] = 1'b0; abort[0] = 1'b0;
    check("start_abort_idle", 33'(busy[0]), 33'd0);
    tick();

    // Extra start mid-run is ignored; timing unchanged.
    run(0, 1'b1, lat);
    check("lat_restart_ign", 33'(lat), 33'd17);
    check("res_restart_ign", 33'(res_of(0)), 33'({1'b1, 5'd0, 1'b0, 4'd0}));
    tick();

    // Reset at v=9, then a fresh sweep completes normally.
    start[0] = 1'b1; tick(); start[0] = 1'b0;
    wait_vec(0, 4'd9);
    rst_n[0] = 1'b0; tick(); rst_n[0] = 1'b1;
    check("midreset_zero", act_of(0), 33'd0);
    tick();
    run(0, 1'b0, lat);
    check("lat_after_rst", 33'(lat), 33'd17);
    check("res_after_rst", 33'(res_of(0)), 33'({1'b1, 5'd0, 1'b0, 4'd0}));
    tick();

    // Expected signature of a correct sweep, derived from the table.
    gold_sig = '0;
    for (int v = 0; v < 16; v++) gold_sig = misr_step(gold_sig, {9'b0, 4'(v), resp(F_NONE, 4'(v))});
    run(0, 1'b0, lat);
`ifdef CASE1_SWEEP_MISR_EN
    check("sig_good_1", 33'(sig[0]), 33'(gold_sig));
    check("sig_nonzero", 33'(sig[0] != 16'h0), 33'd1);
    tick();
    run(0, 1'b0, lat);
    check("sig_good_2", 33'(sig[0]), 33'(gold_sig));
    tick();
    fault[0] = F_Y5FLIP;
    run(0, 1'b0, lat);
    check("sig_y5_differs", 33'(sig[0] != gold_sig), 33'd1);
    fault[0] = F_NONE;
`else
    check("sig_off_dut1", 33'(sig[0]), 33'd0);
    check("sig_off_dut4", 33'(sig[1]), 33'd0);
`endif
    tick();

    // Random traffic on both instances against the per-cycle model.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NI; i++) begin
        rst_n[i] = ($urandom_range(0, 149) != 0);
        start[i] = ($urandom_range(0, 5) == 0);
        abort[i] = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 63) == 0) fault[i] = int'($urandom_range(0, 3));
      end
      tick();
    end
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b1; start[i] = 1'b0; abort[i] = 1'b0;
    end
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
